// File: rtl/regfile_write_arbiter.sv
// Two-source register-file write arbiter. Each source has a one-entry holding buffer.
// When both buffers are pending, the older entry wins. A tie between two new entries goes to the source that was not granted last.
module regfile_write_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              grant_mem,
    output logic [7:0]        conflict_cnt
);

    logic              pend_alu;
    logic              pend_mem;
    logic [ADDR_W-1:0] addr_alu;
    logic [ADDR_W-1:0] addr_mem;
    logic [DATA_W-1:0] data_alu;
    logic [DATA_W-1:0] data_mem;
    logic              older_mem;       // 1: the mem entry arrived before the alu entry
    logic              last_grant_mem;  // 1: the most recent grant went to mem
    logic              gnt_alu;
    logic              gnt_mem;
    logic              load_alu;
    logic              load_mem;
    logic              older_mem_nxt;
    logic              last_grant_mem_nxt;

    // Grants depend only on registered state, so ready has no path from valid.
    always_comb begin
        gnt_alu = pend_alu & (~pend_mem | ~older_mem);
        gnt_mem = pend_mem & (~pend_alu | older_mem);
    end

    assign alu_ready = ~pend_alu | gnt_alu;
    assign mem_ready = ~pend_mem | gnt_mem;
    assign load_alu  = alu_valid & alu_ready;
    assign load_mem  = mem_valid & mem_ready;

    always_comb begin
        last_grant_mem_nxt = last_grant_mem;
        if (gnt_mem) begin
            last_grant_mem_nxt = 1'b1;
        end else if (gnt_alu) begin
            last_grant_mem_nxt = 1'b0;
        end

        older_mem_nxt = older_mem;
        if (load_alu && load_mem) begin
            older_mem_nxt = ~last_grant_mem_nxt;
        end else if (load_alu) begin
            older_mem_nxt = 1'b1;
        end else if (load_mem) begin
            older_mem_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_alu       <= 1'b0;
            pend_mem       <= 1'b0;
            addr_alu       <= '0;
            addr_mem       <= '0;
            data_alu       <= '0;
            data_mem       <= '0;
            older_mem      <= 1'b0;
            last_grant_mem <= 1'b1;
            rf_we          <= 1'b0;
            rf_waddr       <= '0;
            rf_wdata       <= '0;
            grant_mem      <= 1'b0;
            conflict_cnt   <= 8'd0;
        end else begin
            if (load_alu) begin
                pend_alu <= 1'b1;
                addr_alu <= alu_addr;
                data_alu <= alu_data;
            end else if (gnt_alu) begin
                pend_alu <= 1'b0;
            end

            if (load_mem) begin
                pend_mem <= 1'b1;
                addr_mem <= mem_addr;
                data_mem <= mem_data;
            end else if (gnt_mem) begin
                pend_mem <= 1'b0;
            end

            older_mem      <= older_mem_nxt;
            last_grant_mem <= last_grant_mem_nxt;
            rf_we          <= gnt_alu | gnt_mem;

            if (gnt_mem) begin
                rf_waddr  <= addr_mem;
                rf_wdata  <= data_mem;
                grant_mem <= 1'b1;
            end else if (gnt_alu) begin
                rf_waddr  <= addr_alu;
                rf_wdata  <= data_alu;
                grant_mem <= 1'b0;
            end

            if (pend_alu && pend_mem && conflict_cnt != 8'hFF) begin
                conflict_cnt <= conflict_cnt + 8'd1;
            end
        end
    end

endmodule
